// File: rtl/wb_queue.sv
// Writeback queue between the execute pipeline and a single register-file write port.
// Define WBQ_BYPASS_EN to forward the youngest queued data onto rd1/rd2.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [5:0]                 in_wa,
  input  logic [31:0]                in_wd,
  output logic                       in_ready,
  input  logic                       stall,
  output logic                       we1,
  output logic [5:0]                 wa,
  output logic [31:0]                wd,
  input  logic [5:0]                 ra1,
  input  logic [5:0]                 ra2,
  input  logic [31:0]                rf_rd1,
  input  logic [31:0]                rf_rd2,
  output logic [31:0]                rd1,
  output logic [31:0]                rd2,
  output logic                       hit1,
  output logic                       hit2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [5:0]    addr_q [DEPTH];
  logic [5:0]    addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          enq;
  logic          deq;

  // Ring slot holding the entry that is k places younger than the head.
  function automatic logic [AW-1:0] slot(input logic [AW-1:0] head, input int k);
    return head + AW'(k);
  endfunction

  // Queue status and the write port, all decoded from current state.
  always_comb begin
    empty    = (count_q == CW'(0));
    full     = (count_q == CW'(DEPTH));
    count    = count_q;
    in_ready = !full;
    we1      = !empty && !stall && !rst;
    enq      = in_valid && !full;
    deq      = we1;
    if (empty) begin
      wa = 6'd0;
      wd = 32'd0;
    end else begin
      wa = addr_q[head_q];
      wd = data_q[head_q];
    end
  end

  // Next-state for pointers, occupancy and entry storage.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    tail_d  = tail_q;
    head_d  = head_q;
    count_d = count_q;
    if (enq) begin
      addr_d[tail_q] = in_wa;
      data_d[tail_q] = in_wd;
      tail_d         = tail_q + AW'(1);
    end else begin
      tail_d = tail_q;
    end
    if (deq) begin
      head_d = head_q + AW'(1);
    end else begin
      head_d = head_q;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef WBQ_BYPASS_EN
  logic [31:0] fwd1;
  logic [31:0] fwd2;
`endif

  // Address match against live entries, walked oldest to youngest so the youngest wins.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
`ifdef WBQ_BYPASS_EN
    fwd1 = 32'd0;
    fwd2 = 32'd0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q) begin
        if (addr_q[slot(head_q, k)] == ra1) begin
          hit1 = 1'b1;
`ifdef WBQ_BYPASS_EN
          fwd1 = data_q[slot(head_q, k)];
`endif
        end else begin
          hit1 = hit1;
        end
        if (addr_q[slot(head_q, k)] == ra2) begin
          hit2 = 1'b1;
`ifdef WBQ_BYPASS_EN
          fwd2 = data_q[slot(head_q, k)];
`endif
        end else begin
          hit2 = hit2;
        end
      end else begin
        hit1 = hit1;
      end
    end
  end

  // Read data seen by decode.
  always_comb begin
`ifdef WBQ_BYPASS_EN
    rd1 = hit1 ? fwd1 : rf_rd1;
    rd2 = hit2 ? fwd2 : rf_rd2;
`else
    rd1 = rf_rd1;
    rd2 = rf_rd2;
`endif
  end

  // Control state; reset drops every pending entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; stale contents stay hidden behind count_q.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queued writebacks; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning the producer offers a writeback.
REQ-005 The block SHALL have port in_wa, input, 6 bits, the destination register of the offered writeback.
REQ-006 The block SHALL have port in_wd, input, 32 bits, the data of the offered writeback.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the queue can accept an entry this cycle.
REQ-008 The block SHALL have port stall, input, 1 bit, meaning the register-file write port is unavailable this cycle.
REQ-009 The block SHALL have ports we1 (1 bit), wa (6 bits) and wd (32 bits), all outputs, driving the register-file write port.
REQ-010 The block SHALL have ports ra1 and ra2, inputs, 6 bits each, the decode-stage read addresses.
REQ-011 The block SHALL have ports rf_rd1 and rf_rd2, inputs, 32 bits each, the raw register-file read data.
REQ-012 The block SHALL have ports rd1 and rd2, outputs, 32 bits each, the coherent read data.
REQ-013 The block SHALL have ports hit1 and hit2, outputs, 1 bit each, meaning ra1 or ra2 matches a queued entry.
REQ-014 The block SHALL have ports count (clog2(DEPTH)+1 bits), empty (1 bit) and full (1 bit), all outputs, giving queue status.

Function
REQ-015 The block SHALL hold an in-order circular buffer of DEPTH {addr[5:0], data[31:0]} entries with head and tail pointers that wrap modulo DEPTH.
REQ-016 The block SHALL drive in_ready = !full, combinationally, with no dependence on stall.
REQ-017 The block SHALL enqueue at the tail on every rising edge where in_valid && in_ready; if in_valid is high while full, it SHALL neither enqueue nor corrupt any state.
REQ-018 The block SHALL drive we1 = !empty && !stall, with wa and wd equal to the head entry; wa and wd SHALL be 0 when the queue is empty.
REQ-019 The block SHALL dequeue the head on every rising edge where we1 is high, so at most one write drains per cycle.
REQ-020 An entry accepted into an empty queue SHALL appear on we1 in the next cycle, giving 1-cycle minimum latency; the offered entry SHALL NOT be passed through in the same cycle.
REQ-021 A simultaneous enqueue and dequeue SHALL leave count unchanged; empty and full SHALL be decoded from count, which ranges from 0 to DEPTH.
REQ-022 Multiple queued entries to the same address SHALL all be written in order, with no merging.
REQ-023 hitN SHALL be 1 iff raN equals the addr of any valid entry, including the head being written this cycle; in_wa SHALL NOT be considered.
REQ-024 On a hit, the matched data SHALL be that of the youngest (closest to tail) matching entry.
REQ-025 The matching logic SHALL be correct after pointer wrap-around, with age measured from head and not by raw index.

Reset
REQ-026 While rst is high at a rising edge, head, tail and count SHALL become 0 and any pending entries SHALL be discarded, including mid-drain, with no write issued.
REQ-027 The first cycle after reset SHALL show we1=0, wa=0, wd=0, count=0, empty=1, full=0, in_ready=1, hit1=0 and hit2=0; rd1 and rd2 SHALL follow rf_rd1 and rf_rd2.
REQ-028 Entry storage need not be cleared on reset, but it SHALL never be visible while its entry is invalid.

Configuration
REQ-029 With macro WBQ_BYPASS_EN defined, rdN SHALL be the youngest matching entry's data when hitN is 1, else rf_rdN.
REQ-030 Without WBQ_BYPASS_EN, rdN SHALL equal rf_rdN unconditionally, no forwarding mux SHALL be built, and hitN SHALL still be produced so decode can stall on it.

Verification
REQ-031 The bench SHALL cover this case: after reset, offer (wa=5, wd=0xDEADBEEF) with stall=0 -> the next cycle shows we1=1, wa=5, wd=0xDEADBEEF, then the queue is empty.
REQ-032 The bench SHALL cover this case: with stall=1, offer 5 entries at DEPTH=4 -> the first 4 are accepted, full=1 and in_ready=0, the 5th is held; releasing stall drains them in order over 4 cycles.
REQ-033 The bench SHALL cover this case: queue (7,0x11) then (7,0x22) with stall=1, and ra1=7 -> hit1=1 and rd1=0x22 with the macro, rd1=rf_rd1 without it.
REQ-034 The bench SHALL cover this case: run 10 enqueue/dequeue cycles so the pointers wrap, then queue (3,0xA) and (3,0xB) across the wrap boundary -> rd2 for ra2=3 is 0xB.
REQ-035 The bench SHALL cover this case: with 3 entries pending, assert rst for one cycle -> the next cycle shows count=0, we1=0, and no write of the pending entries ever appears.
REQ-036 The bench SHALL cover this case: when full and draining with stall=0, assert in_valid -> the offer is not accepted that cycle and is accepted the next cycle, when in_ready=1.
